// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALUcon operation codes and execute-stage FSM state encoding
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_BGEZ = 4'b0011;
    localparam logic [3:0] ALU_BGTZ = 4'b0100;
    localparam logic [3:0] ALU_BLEZ = 4'b0101;
    localparam logic [3:0] ALU_AND  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1010;
    localparam logic [3:0] ALU_XOR  = 4'b1011;
    localparam logic [3:0] ALU_SLL  = 4'b1100;
    localparam logic [3:0] ALU_SRL  = 4'b1101;
    localparam logic [3:0] ALU_SLT  = 4'b1110;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - iterative shift-add multiplier, one multiplicand bit per cycle
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             run_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             step;

    assign step      = run_i & ~abort_i;
    // Product is taken from the accumulator value of the final step so it lands in the same cycle.
    assign product_o = acc_q + (mcand_q[0] ? mplier_q : '0);
    assign done_o    = step & (count_q == CNT_W'(WIDTH - 1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        if (start_i) begin
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            acc_d    = '0;
            count_d  = '0;
        end else if (abort_i) begin
            count_d  = '0;
        end else if (step) begin
            acc_d    = product_o;
            mplier_d = mplier_q << 1;
            mcand_d  = mcand_q >> 1;
            count_d  = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_exec_mc.sv
// rtl/alu_exec_mc.sv - execute-stage ALU with single-cycle ops and a stalling multi-cycle multiply
module alu_exec_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    input  logic             Flush,
    input  logic [3:0]       ALUcon,
    input  logic             shift,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             OutValid,
    output logic             Stall
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;
    logic [4:0]       sa;
    logic             a_gtz;

    logic             mul_start, mul_abort, mul_done;
    logic [WIDTH-1:0] mul_product;

    assign sa    = shift ? shamt : A[4:0];
    assign a_gtz = $signed(A) > $signed({WIDTH{1'b0}});

    always_comb begin
        alu_res  = '0;
        alu_zero = 1'b0;
        unique case (ALUcon)
            ALU_ADD:  alu_res = A + B;
            ALU_SUB:  alu_res = A - B;
            ALU_BGEZ: alu_res = A;
            ALU_BGTZ: alu_res = A;
            ALU_BLEZ: alu_res = A;
            ALU_AND:  alu_res = A & B;
            ALU_OR:   alu_res = A | B;
            ALU_NOR:  alu_res = ~(A | B);
            ALU_XOR:  alu_res = A ^ B;
            ALU_SLL:  alu_res = B << sa;
            ALU_SRL:  alu_res = B >> sa;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            default:  alu_res = '0;
        endcase
        case (ALUcon)
            ALU_SUB:  alu_zero = (A == B);
            ALU_BGEZ: alu_zero = ~A[WIDTH-1];
            ALU_BGTZ: alu_zero = a_gtz;
            ALU_BLEZ: alu_zero = ~a_gtz;
            default:  alu_zero = (alu_res == '0);
        endcase
    end

    // Inputs are not looked at while multiplying; upstream is frozen by Stall.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        valid_d   = 1'b0;
        mul_start = 1'b0;
        mul_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (InValid && !Flush) begin
                    if (ALUcon == ALU_MUL) begin
                        mul_start = 1'b1;
                        state_d   = MUL;
                    end else begin
                        result_d = alu_res;
                        zero_d   = alu_zero;
                        valid_d  = 1'b1;
                    end
                end
            end
            MUL: begin
                if (Flush) begin
                    mul_abort = 1'b1;
                    state_d   = IDLE;
                end else if (mul_done) begin
                    result_d = mul_product;
                    zero_d   = (mul_product == '0);
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul_seq (
        .clk_i     (Clk),
        .rstn_i    (Rst),
        .start_i   (mul_start),
        .abort_i   (mul_abort),
        .run_i     (state_q == MUL),
        .mcand_i   (A),
        .mplier_i  (B),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign OutValid  = valid_q;
    assign Stall     = (state_q == MUL);

endmodule

// File: tb/tb_alu_exec_mc.sv
// tb/tb_alu_exec_mc.sv - directed self-checking bench for alu_exec_mc
module tb_alu_exec_mc;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        InValid;
    logic        Flush;
    logic [3:0]  ALUcon;
    logic        shift;
    logic [4:0]  shamt;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        OutValid;
    logic        Stall;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_mc #(.WIDTH(32)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .InValid   (InValid),
        .Flush     (Flush),
        .ALUcon    (ALUcon),
        .shift     (shift),
        .shamt     (shamt),
        .A         (A),
        .B         (B),
        .ALUResult (ALUResult),
        .Zero      (Zero),
        .OutValid  (OutValid),
        .Stall     (Stall)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drives one instruction for a single edge, then drops InValid; checks follow at edge+1.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic sh, input logic [4:0] sam, input logic fl);
        ALUcon  = op;
        A       = a;
        B       = b;
        shift   = sh;
        shamt   = sam;
        Flush   = fl;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        Flush   = 1'b0;
    endtask

    task automatic expect_op(input string tag, input logic [31:0] res, input logic z);
        check_eq({tag, "_res"}, ALUResult, res);
        check_eq({tag, "_zero"}, {31'b0, Zero}, {31'b0, z});
        check_eq({tag, "_valid"}, {31'b0, OutValid}, 32'd1);
    endtask

    initial begin
        int stall_cycles;
        int pulses;

        Rst = 1'b0; Flush = 1'b0; InValid = 1'b0;
        ALUcon = '0; shift = 1'b0; shamt = '0; A = '0; B = '0;

        for (int i = 0; i < 2; i++) begin
            InValid = 1'($urandom);
            Flush   = 1'($urandom);
            ALUcon  = 4'($urandom);
            A       = $urandom;
            B       = $urandom;
            tick();
        end
        check_eq("rst_result", ALUResult, 32'd0);
        check_eq("rst_zero",   {31'b0, Zero},     32'd0);
        check_eq("rst_valid",  {31'b0, OutValid}, 32'd0);
        check_eq("rst_stall",  {31'b0, Stall},    32'd0);
        Rst = 1'b1; InValid = 1'b0; Flush = 1'b0;
        tick();

        issue(4'b0001, 32'd5, 32'd5, 1'b0, 5'd0, 1'b0);
        expect_op("sub_eq", 32'd0, 1'b1);
        tick();
        check_eq("sub_valid_drop", {31'b0, OutValid}, 32'd0);

        // Back-to-back issue on consecutive edges
        issue(4'b1110, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd0, 1'b0);
        expect_op("slt", 32'd1, 1'b0);
        issue(4'b1100, 32'h0000_0003, 32'h1, 1'b1, 5'd4, 1'b0);
        expect_op("sll_shamt", 32'h10, 1'b0);
        issue(4'b1101, 32'd31, 32'h8000_0000, 1'b0, 5'd9, 1'b0);
        expect_op("srl_rega", 32'd1, 1'b0);
        issue(4'b0000, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd0, 1'b0);
        expect_op("add_wrap", 32'd0, 1'b1);
        issue(4'b1010, 32'hF0F0_0000, 32'h0000_00FF, 1'b0, 5'd0, 1'b0);
        expect_op("nor", 32'h0F0F_FF00, 1'b0);
        issue(4'b1011, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b0, 5'd0, 1'b0);
        expect_op("xor", 32'h5A5A_A5A5, 1'b0);
        issue(4'b0111, 32'h1234_5678, 32'h9, 1'b0, 5'd0, 1'b0);
        expect_op("undef", 32'd0, 1'b1);

        issue(4'b0100, 32'd0, 32'd7, 1'b0, 5'd0, 1'b0);
        expect_op("bgtz_0", 32'd0, 1'b0);
        issue(4'b0101, 32'd0, 32'd7, 1'b0, 5'd0, 1'b0);
        expect_op("blez_0", 32'd0, 1'b1);
        issue(4'b0011, 32'h8000_0000, 32'd7, 1'b0, 5'd0, 1'b0);
        expect_op("bgez_neg", 32'h8000_0000, 1'b0);
        issue(4'b0100, 32'd6, 32'd0, 1'b0, 5'd0, 1'b0);
        expect_op("bgtz_pos", 32'd6, 1'b1);
        tick();

        // mul -3 * 7: Stall for exactly 32 cycles, result after edge k+32
        issue(4'b0010, 32'hFFFF_FFFD, 32'd7, 1'b0, 5'd0, 1'b0);
        stall_cycles = 0;
        while (Stall && stall_cycles < 40) begin
            check_eq("mul_no_early_valid", {31'b0, OutValid}, 32'd0);
            stall_cycles++;
            tick();
        end
        check_eq("mul_stall_len", stall_cycles, 32'd32);
        expect_op("mul_neg", 32'hFFFF_FFEB, 1'b0);
        tick();
        check_eq("mul_valid_drop", {31'b0, OutValid}, 32'd0);

        issue(4'b0010, 32'h0001_0000, 32'h0001_0000, 1'b0, 5'd0, 1'b0);
        stall_cycles = 0;
        while (Stall && stall_cycles < 40) begin
            stall_cycles++;
            tick();
        end
        check_eq("mul0_stall_len", stall_cycles, 32'd32);
        expect_op("mul_ovf", 32'd0, 1'b1);
        tick();

        issue(4'b0000, 32'h1234, 32'd1, 1'b0, 5'd0, 1'b0);
        expect_op("add_pre_flush", 32'h1235, 1'b0);
        tick();

        // Flush at cycle 10 of a multiply
        issue(4'b0010, 32'd9, 32'd9, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        check_eq("flush_pre_stall", {31'b0, Stall}, 32'd1);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check_eq("flush_stall", {31'b0, Stall},    32'd0);
        check_eq("flush_valid", {31'b0, OutValid}, 32'd0);
        check_eq("flush_keep",  ALUResult,         32'h1235);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (OutValid) pulses++;
            tick();
        end
        check_eq("flush_no_late_valid", pulses, 32'd0);

        issue(4'b0000, 32'd10, 32'd20, 1'b0, 5'd0, 1'b1);
        check_eq("flush_add_valid", {31'b0, OutValid}, 32'd0);
        check_eq("flush_add_keep",  ALUResult,         32'h1235);

        // Reset in the middle of a multiply
        issue(4'b0010, 32'd5, 32'd6, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 14; i++) tick();
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        check_eq("mrst_result", ALUResult, 32'd0);
        check_eq("mrst_zero",   {31'b0, Zero},     32'd0);
        check_eq("mrst_valid",  {31'b0, OutValid}, 32'd0);
        check_eq("mrst_stall",  {31'b0, Stall},    32'd0);
        issue(4'b0000, 32'd2, 32'd3, 1'b0, 5'd0, 1'b0);
        expect_op("add_after_rst", 32'd5, 1'b0);
        tick();
        check_eq("add_after_rst_drop", {31'b0, OutValid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
